// File: rtl/multicycle_ctrl_fsm_if.sv
// Instruction-register fields, memory handshake and datapath control strobes
// shared between the multicycle controller and its environment.
interface multicycle_ctrl_fsm_if #(
  parameter int OPW  = 4,
  parameter int FFW  = 4,
  parameter int CNTW = 16
);
  // Handshake: mem_ready is looked at only in FETCH and MEM. An access completes on the
  // rising edge where the controller's strobe (MemRead/MemWrite) and mem_ready are both high;
  // otherwise the strobe is held. A held access that runs too long ends in a bus_error trap.
  logic [OPW-1:0]  opcode;
  logic [FFW-1:0]  func_field;
  logic            mem_ready;
  logic            stall_req;

  logic [1:0]      PCSrc;
  logic [2:0]      ALUOp;
  logic            sign_extend;
  logic            ALUSrcA;
  logic [2:0]      ALUSrcB;
  logic [1:0]      ReadR1;
  logic            ReadR2;
  logic            RegWriteDst;
  logic            MemToReg;
  logic            PCBEqCond;
  logic            PCBNqCond;
  logic            PCWrite;
  logic            MemWrite;
  logic            MemRead;
  logic            IRWrite;
  logic            RegWrite;
  logic            illegal_op;
  logic            bus_error;
  logic [2:0]      state_o;
  logic [CNTW-1:0] retired_count;

  modport master (
    output opcode, func_field, mem_ready, stall_req,
    input  PCSrc, ALUOp, sign_extend, ALUSrcA, ALUSrcB, ReadR1, ReadR2,
           RegWriteDst, MemToReg, PCBEqCond, PCBNqCond, PCWrite, MemWrite,
           MemRead, IRWrite, RegWrite, illegal_op, bus_error, state_o, retired_count
  );

  modport slave (
    input  opcode, func_field, mem_ready, stall_req,
    output PCSrc, ALUOp, sign_extend, ALUSrcA, ALUSrcB, ReadR1, ReadR2,
           RegWriteDst, MemToReg, PCBEqCond, PCBNqCond, PCWrite, MemWrite,
           MemRead, IRWrite, RegWrite, illegal_op, bus_error, state_o, retired_count
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle controller for the 16-bit datapath: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory wait/timeout, decode stall, illegal-opcode trap and a retired-instruction counter.
module multicycle_ctrl_fsm #(
  parameter int OPW         = 4,
  parameter int FFW         = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNTW        = 16
) (
  input logic                clk,
  input logic                rst,
  multicycle_ctrl_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_ILL  = 2'd1,
    CAUSE_BUS  = 2'd2
  } cause_t;

  typedef struct packed {
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       sign_extend;
    logic       alu_src_a;
    logic [2:0] alu_src_b;
    logic [1:0] read_r1;
    logic       read_r2;
    logic       reg_write_dst;
    logic       mem_to_reg;
    logic       pcb_eq_cond;
    logic       pcb_nq_cond;
    logic       pc_write;
    logic       mem_write;
    logic       mem_read;
    logic       ir_write;
    logic       reg_write;
    logic       illegal_op;
    logic       bus_error;
  } ctrl_t;

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t          state_q, state_d;
  cause_t          cause_q, cause_d;
  logic [7:0]      wait_q, wait_d;
  logic [CNTW-1:0] cnt_q;
  logic            retire;
  ctrl_t           ctrl, ctrl_o;

  // Instruction decode
  logic [OPW-1:0] op;
  logic [FFW-1:0] fn;
  logic [3:0]     op4, fn4;
  logic           op_hi_ok, fn_hi_ok;
  logic           dec_alu, dec_imm, dec_shift, dec_beq, dec_bnq, dec_jmp, dec_lw, dec_sw;
  logic           dec_legal, dec_sext;
  logic [2:0]     dec_alu_op;

  assign op       = bus.opcode;
  assign fn       = bus.func_field;
  assign op4      = op[3:0];
  assign fn4      = fn[3:0];
  assign op_hi_ok = ((op >> 4) == '0);
  assign fn_hi_ok = ((fn >> 4) == '0);

  always_comb begin
    dec_alu    = 1'b0;
    dec_imm    = 1'b0;
    dec_shift  = 1'b0;
    dec_sext   = 1'b0;
    dec_beq    = 1'b0;
    dec_bnq    = 1'b0;
    dec_jmp    = 1'b0;
    dec_lw     = 1'b0;
    dec_sw     = 1'b0;
    dec_alu_op = 3'b000;
    if (op_hi_ok) begin
      case (op4)
        4'b1000: dec_alu = 1'b1;
        4'b1001: begin dec_alu = 1'b1; dec_imm = 1'b1; dec_sext = 1'b1; end
        4'b1010: begin dec_alu = 1'b1; dec_imm = 1'b1; end
        4'b1100: begin dec_alu = 1'b1; dec_alu_op = 3'b001; end
        4'b1101: begin dec_alu = 1'b1; dec_alu_op = 3'b001; dec_imm = 1'b1; dec_sext = 1'b1; end
        4'b1110: begin dec_alu = 1'b1; dec_alu_op = 3'b001; dec_imm = 1'b1; end
        4'b1011: begin dec_alu = 1'b1; dec_alu_op = 3'b010; end
        4'b0111: begin dec_alu = 1'b1; dec_alu_op = 3'b010; dec_imm = 1'b1; end
        4'b1111: begin dec_alu = 1'b1; dec_alu_op = 3'b101; end
        4'b0110: begin dec_alu = 1'b1; dec_alu_op = 3'b101; dec_imm = 1'b1; dec_sext = 1'b1; end
        4'b0100: dec_beq = 1'b1;
        4'b0101: dec_bnq = 1'b1;
        4'b0011: dec_jmp = 1'b1;
        4'b0001: dec_lw  = 1'b1;
        4'b0010: dec_sw  = 1'b1;
        4'b0000: begin
          // Shift group: func_field picks the shift; anything else is illegal
          if (fn_hi_ok) begin
            case (fn4)
              4'd1: begin dec_alu = 1'b1; dec_shift = 1'b1; dec_alu_op = 3'b011; end
              4'd2: begin dec_alu = 1'b1; dec_shift = 1'b1; dec_alu_op = 3'b100; end
              4'd3: begin dec_alu = 1'b1; dec_shift = 1'b1; dec_alu_op = 3'b111; end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign dec_legal = dec_alu | dec_beq | dec_bnq | dec_jmp | dec_lw | dec_sw;

  // Next state and control outputs
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    wait_d  = wait_q;
    retire  = 1'b0;
    ctrl    = '0;
    case (state_q)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 3'b001;
        if (bus.mem_ready) begin
          ctrl.pc_write = 1'b1;
          ctrl.ir_write = 1'b1;
          state_d       = DECODE;
        end else if (wait_q == TO_LAST) begin
          state_d = TRAP;
          cause_d = CAUSE_BUS;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      DECODE: begin
        if (!bus.stall_req) begin
          if (dec_legal) begin
            state_d = EXEC;
          end else begin
            state_d = TRAP;
            cause_d = CAUSE_ILL;
          end
        end
      end
      EXEC: begin
        if (dec_alu) begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_src_b     = dec_imm ? 3'b010 : (dec_shift ? 3'b101 : 3'b000);
          ctrl.alu_op        = dec_alu_op;
          ctrl.sign_extend   = dec_sext;
          ctrl.read_r1       = dec_imm ? 2'b01 : 2'b00;
          ctrl.reg_write_dst = 1'b1;
          state_d            = WB;
        end else if (dec_beq || dec_bnq) begin
          ctrl.alu_op      = 3'b001;
          ctrl.pc_src      = 2'b01;
          ctrl.pcb_eq_cond = dec_beq;
          ctrl.pcb_nq_cond = dec_bnq;
          state_d          = FETCH;
          retire           = 1'b1;
        end else if (dec_jmp) begin
          ctrl.alu_src_b = 3'b100;
          ctrl.pc_write  = 1'b1;
          state_d        = FETCH;
          retire         = 1'b1;
        end else if (dec_lw || dec_sw) begin
          ctrl.alu_src_b   = 3'b011;
          ctrl.sign_extend = 1'b1;
          ctrl.read_r1     = 2'b10;
          ctrl.read_r2     = 1'b1;
          state_d          = MEM;
        end else begin
          state_d = FETCH;
        end
      end
      MEM: begin
        ctrl.mem_read  = dec_lw;
        ctrl.mem_write = dec_sw;
        ctrl.read_r2   = dec_sw;
        if (bus.mem_ready) begin
          state_d = dec_lw ? WB : FETCH;
          retire  = !dec_lw;
        end else if (wait_q == TO_LAST) begin
          state_d = TRAP;
          cause_d = CAUSE_BUS;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      WB: begin
        ctrl.reg_write     = 1'b1;
        ctrl.reg_write_dst = 1'b1;
        ctrl.mem_to_reg    = dec_lw;
        state_d            = FETCH;
        retire             = 1'b1;
      end
      TRAP: begin
        ctrl.pc_src     = 2'b10;
        ctrl.pc_write   = 1'b1;
        ctrl.illegal_op = (cause_q == CAUSE_ILL);
        ctrl.bus_error  = (cause_q == CAUSE_BUS);
        cause_d         = CAUSE_NONE;
        state_d         = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // Every state change starts a fresh wait window for the next access
    if (state_d != state_q) wait_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      cause_q <= CAUSE_NONE;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      wait_q  <= wait_d;
      if (retire) cnt_q <= cnt_q + CNTW'(1);
    end
  end

  // Outputs forced quiet for the whole time reset is held, not just from the next edge
  assign ctrl_o = rst ? '0 : ctrl;

  assign bus.PCSrc         = ctrl_o.pc_src;
  assign bus.ALUOp         = ctrl_o.alu_op;
  assign bus.sign_extend   = ctrl_o.sign_extend;
  assign bus.ALUSrcA       = ctrl_o.alu_src_a;
  assign bus.ALUSrcB       = ctrl_o.alu_src_b;
  assign bus.ReadR1        = ctrl_o.read_r1;
  assign bus.ReadR2        = ctrl_o.read_r2;
  assign bus.RegWriteDst   = ctrl_o.reg_write_dst;
  assign bus.MemToReg      = ctrl_o.mem_to_reg;
  assign bus.PCBEqCond     = ctrl_o.pcb_eq_cond;
  assign bus.PCBNqCond     = ctrl_o.pcb_nq_cond;
  assign bus.PCWrite       = ctrl_o.pc_write;
  assign bus.MemWrite      = ctrl_o.mem_write;
  assign bus.MemRead       = ctrl_o.mem_read;
  assign bus.IRWrite       = ctrl_o.ir_write;
  assign bus.RegWrite      = ctrl_o.reg_write;
  assign bus.illegal_op    = ctrl_o.illegal_op;
  assign bus.bus_error     = ctrl_o.bus_error;
  assign bus.state_o       = rst ? 3'd0 : state_q;
  assign bus.retired_count = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed and randomized instruction sequences for multicycle_ctrl_fsm, checked per cycle
// against an instruction-level model of the expected state trace and control strobes.
module tb_multicycle_ctrl_fsm;

  localparam int OPW = 5;
  localparam int FFW = 5;
  localparam int T   = 15;
  localparam int CNTW = 4;

  localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC = 2, S_MEM = 3, S_WB = 4, S_TRAP = 5;
  localparam int K_ILL = 0, K_ALU = 1, K_BEQ = 2, K_BNQ = 3, K_JMP = 4, K_LW = 5, K_SW = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if #(.OPW(OPW), .FFW(FFW), .CNTW(CNTW)) bus ();

  multicycle_ctrl_fsm #(.OPW(OPW), .FFW(FFW), .MEM_TIMEOUT(T), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad = 0;
  int step_id = 0;
  int exp_cnt = 0;

  logic [2:0] exp_q[$];
  bit         rdy_q[$];
  bit         stl_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_id, obs, exp_v);
    end
  endtask

  function automatic logic [22:0] obs_ctrl();
    return {bus.PCSrc, bus.ALUOp, bus.sign_extend, bus.ALUSrcB, bus.ReadR1, bus.ReadR2,
            bus.RegWriteDst, bus.MemToReg, bus.PCBEqCond, bus.PCBNqCond, bus.PCWrite,
            bus.MemWrite, bus.MemRead, bus.IRWrite, bus.RegWrite, bus.illegal_op, bus.bus_error};
  endfunction

  function automatic logic [30:0] obs_all();
    return {obs_ctrl(), bus.ALUSrcA, bus.state_o, bus.retired_count};
  endfunction

  // Instruction set table: kind, ALU operation, operand-B source, sign-extend, read-port-1 field
  task automatic classify(input int op, input int fn, output int kind, output int aop,
                          output int srcb, output bit sx, output int rr1);
    kind = K_ILL; aop = 0; srcb = 0; sx = 0; rr1 = 0;
    case (op)
      8:  kind = K_ALU;
      9:  begin kind = K_ALU; srcb = 2; sx = 1; rr1 = 1; end
      10: begin kind = K_ALU; srcb = 2; rr1 = 1; end
      12: begin kind = K_ALU; aop = 1; end
      13: begin kind = K_ALU; aop = 1; srcb = 2; sx = 1; rr1 = 1; end
      14: begin kind = K_ALU; aop = 1; srcb = 2; rr1 = 1; end
      11: begin kind = K_ALU; aop = 2; end
      7:  begin kind = K_ALU; aop = 2; srcb = 2; rr1 = 1; end
      15: begin kind = K_ALU; aop = 5; end
      6:  begin kind = K_ALU; aop = 5; srcb = 2; sx = 1; rr1 = 1; end
      4:  begin kind = K_BEQ; aop = 1; end
      5:  begin kind = K_BNQ; aop = 1; end
      3:  begin kind = K_JMP; srcb = 4; end
      1:  begin kind = K_LW; srcb = 3; sx = 1; rr1 = 2; end
      2:  begin kind = K_SW; srcb = 3; sx = 1; rr1 = 2; end
      0:  begin
        if (fn == 1)      begin kind = K_ALU; aop = 3; srcb = 5; end
        else if (fn == 2) begin kind = K_ALU; aop = 4; srcb = 5; end
        else if (fn == 3) begin kind = K_ALU; aop = 7; srcb = 5; end
      end
      default: kind = K_ILL;
    endcase
  endtask

  function automatic logic [22:0] expect_ctrl(input int es, input bit rdy, input int kind,
      input int aop, input int srcb, input bit sx, input int rr1, input bit trap_ill);
    logic [1:0] pc_src, read_r1;
    logic [2:0] alu_op, alu_src_b;
    logic sext, read_r2, rwd, m2r, beq, bnq, pcw, mw, mr, irw, rw, ill, berr;
    bit ex, mem_op;
    ex        = (es == S_EXEC);
    mem_op    = (kind == K_LW) || (kind == K_SW);
    pc_src    = (es == S_TRAP) ? 2'd2 : ((ex && (kind == K_BEQ || kind == K_BNQ)) ? 2'd1 : 2'd0);
    alu_op    = ex ? 3'(aop) : 3'd0;
    sext      = ex && sx;
    alu_src_b = (es == S_FETCH) ? 3'd1 : (ex ? 3'(srcb) : 3'd0);
    read_r1   = ex ? 2'(rr1) : 2'd0;
    read_r2   = (ex && mem_op) || (es == S_MEM && kind == K_SW);
    rwd       = (es == S_WB) || (ex && kind == K_ALU);
    m2r       = (es == S_WB) && (kind == K_LW);
    beq       = ex && (kind == K_BEQ);
    bnq       = ex && (kind == K_BNQ);
    pcw       = (es == S_FETCH && rdy) || (es == S_TRAP) || (ex && kind == K_JMP);
    mw        = (es == S_MEM) && (kind == K_SW);
    mr        = (es == S_FETCH) || (es == S_MEM && kind == K_LW);
    irw       = (es == S_FETCH) && rdy;
    rw        = (es == S_WB);
    ill       = (es == S_TRAP) && trap_ill;
    berr      = (es == S_TRAP) && !trap_ill;
    return {pc_src, alu_op, sext, alu_src_b, read_r1, read_r2, rwd, m2r, beq, bnq,
            pcw, mw, mr, irw, rw, ill, berr};
  endfunction

  // Runs one instruction starting in its first FETCH cycle (called just after a rising edge).
  // fd/md: not-ready cycles before mem_ready in FETCH/MEM; values >= T mean never ready.
  task automatic run_instr(input int op, input int fn, input int fd, input int md, input int stall);
    int kind, aop, srcb, rr1;
    bit sx, trap, trap_ill;
    int n;
    step_id++;
    classify(op, fn, kind, aop, srcb, sx, rr1);
    exp_q.delete(); rdy_q.delete(); stl_q.delete();
    trap = 0; trap_ill = 0;
    n = (fd < T) ? fd + 1 : T;
    for (int i = 0; i < n; i++) begin exp_q.push_back(3'(S_FETCH)); rdy_q.push_back(i == fd); stl_q.push_back(0); end
    if (fd >= T) trap = 1;
    else begin
      for (int i = 0; i <= stall; i++) begin
        exp_q.push_back(3'(S_DECODE)); rdy_q.push_back(1'($urandom_range(0, 1))); stl_q.push_back(i < stall);
      end
      if (kind == K_ILL) begin trap = 1; trap_ill = 1; end
      else begin
        exp_q.push_back(3'(S_EXEC)); rdy_q.push_back(1'($urandom_range(0, 1))); stl_q.push_back(0);
        if (kind == K_LW || kind == K_SW) begin
          n = (md < T) ? md + 1 : T;
          for (int i = 0; i < n; i++) begin exp_q.push_back(3'(S_MEM)); rdy_q.push_back(i == md); stl_q.push_back(0); end
          if (md >= T) trap = 1;
        end
        if (!trap && (kind == K_ALU || kind == K_LW)) begin
          exp_q.push_back(3'(S_WB)); rdy_q.push_back(1'($urandom_range(0, 1))); stl_q.push_back(0);
        end
      end
    end
    if (trap) begin exp_q.push_back(3'(S_TRAP)); rdy_q.push_back(1'($urandom_range(0, 1))); stl_q.push_back(0); end

    bus.opcode     = OPW'(op);
    bus.func_field = FFW'(fn);
    for (int c = 0; c < exp_q.size(); c++) begin
      bus.mem_ready = rdy_q[c];
      bus.stall_req = stl_q[c];
      @(negedge clk);
      chk("state", 32'(bus.state_o), 32'(exp_q[c]));
      chk("ctrl", 32'(obs_ctrl()), 32'(expect_ctrl(int'(exp_q[c]), rdy_q[c], kind, aop, srcb, sx, rr1, trap_ill)));
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b0;
    bus.stall_req = 1'b0;
    if (!trap) exp_cnt = (exp_cnt + 1) % (1 << CNTW);
    chk("retired_count", 32'(bus.retired_count), 32'(exp_cnt));
    chk("back_to_fetch", 32'(bus.state_o), 32'(S_FETCH));
  endtask

  function automatic int rand_delay();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(T - 1, T + 1)) : int'($urandom_range(0, 4));
  endfunction

  initial begin
    rst = 1'b1;
    bus.opcode = '0; bus.func_field = '0; bus.mem_ready = 1'b0; bus.stall_req = 1'b0;

    // Reset holds every output low even though FETCH would otherwise drive MemRead
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", 32'(obs_all()), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    run_instr(8, 0, 0, 0, 0);          // add: 0,1,2,4 then retire
    run_instr(1, 0, 3, 3, 0);          // lw with 3 wait cycles in FETCH and MEM
    run_instr(2, 0, 0, T, 0);          // sw never ready: bus_error trap
    run_instr(0, 5, 0, 0, 0);          // bad shift func: illegal trap
    run_instr(4, 0, 0, 0, 5);          // beq with 5 stall cycles
    run_instr(1, 0, T - 1, T - 1, 0);  // ready on the timeout cycle wins
    run_instr(8, 0, T, 0, 0);          // fetch timeout
    run_instr(17, 0, 0, 0, 0);         // opcode upper bit set: illegal
    run_instr(0, 17, 0, 0, 0);         // func upper bit set: illegal
    run_instr(0, 3, 1, 0, 1);          // sra
    run_instr(3, 0, 0, 0, 0);          // jmp
    run_instr(5, 0, 2, 0, 0);          // bnq

    for (int i = 0; i < 60; i++) begin
      int op, fn;
      op = int'($urandom_range(0, 19));
      fn = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 31)) : int'($urandom_range(0, 3));
      run_instr(op, fn, rand_delay(), rand_delay(), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a store's MEM phase
    step_id++;
    bus.opcode = OPW'(2); bus.func_field = '0; bus.mem_ready = 1'b1;
    @(posedge clk); #1; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_mem", 32'(bus.state_o), 32'(S_MEM));
    chk("pre_reset_memwrite", 32'(bus.MemWrite), 32'd1);
    #2 rst = 1'b1;
    #1 chk("reset_mid_mem", 32'(obs_all()), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("reset_hold", 32'(obs_all()), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 0;

    // Counter wrap: 15 retires reach the top, the 16th rolls over
    for (int i = 0; i < 15; i++) run_instr(8, 0, 0, 0, 0);
    chk("count_top", 32'(bus.retired_count), 32'd15);
    run_instr(8, 0, 0, 0, 0);
    chk("count_wrap", 32'(bus.retired_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
